mac_tx_bd_sched: RTL and testbench
==================================

Name: mac_tx_bd_sched

Overview:
Wishbone master that schedules Tx frames onto the Ethernet MAC's transmit buffer-descriptor ring.
- Accepts frame requests (buffer pointer, length) from a producer and writes them into the next free Tx BD at MAC_BASE+0x400.
- Polls outstanding BDs in order and retires each one when the MAC clears the ready bit, reporting its status.
- Sits between the testbench/DMA producer and the MAC's Wishbone slave port.

Parameters:
- NUM_TX_BD, 8, ring size; 1..128; must equal the value programmed in TX_BD_NUM (0x20).
- MAC_BASE, 32'h0000_0000, Wishbone base address of the MAC.
- POLL_INTERVAL, 16, idle cycles between status polls of the oldest outstanding BD; range 1..65535.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_valid  in  1  frame request valid
- req_ready  out  1  one-cycle pulse: request consumed
- req_ptr  in  32  frame buffer address
- req_len  in  16  frame length in bytes
- req_irq  in  1  set the BD IRQ enable bit
- m_adr_o  out  32  WB address
- m_dat_o  out  32  WB write data
- m_dat_i  in  32  WB read data
- m_we_o  out  1  WB write enable
- m_sel_o  out  4  WB byte select; always 4'hF during a cycle
- m_cyc_o  out  1  WB cycle
- m_stb_o  out  1  WB strobe
- m_ack_i  in  1  WB acknowledge
- m_err_i  in  1  WB error
- done_valid  out  1  one-cycle pulse: BD retired
- done_idx  out  7  index of the retired BD
- done_status  out  9  retired BD word0[8:0]: UR, RTRY[3:0], RL, LC, DF, CS
- outstanding  out  8  number of BDs handed to the MAC and not yet retired
- err_o  out  1  sticky: Wishbone error seen

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs 0.
  - head, tail, outstanding, poll timer cleared; FSM to IDLE.
  - A Wishbone cycle in flight is dropped (cyc/stb low) without waiting for ack.
  - BDs already handed to the MAC are forgotten; the MAC must be reset alongside this block.
- BD address: MAC_BASE + 0x400 + idx*8.
  - Word0 at +0: len[31:16], RD[15], IRQ[14], WR[13], PAD[12], CRC[11], status[8:0].
  - Word1 at +4: buffer pointer.
- Write word0 = {req_len, 1'b1, req_irq, wrap, 1'b1, 1'b1, 11'b0}, where wrap = (head == NUM_TX_BD-1).
- FSM states: IDLE, WR_PTR, WR_CTRL, RD_STAT.
- IDLE priority:
  - (a) outstanding>0 and poll timer==0 -> RD_STAT at tail.
  - (b) else req_valid and outstanding<NUM_TX_BD -> WR_PTR at head.
  - (c) else stay; the poll timer decrements while nonzero and outstanding>0.
- WR_PTR:
  - Single classic write of req_ptr to word1.
  - Hold adr/dat/we/cyc/stb until ack, then -> WR_CTRL.
  - The pointer is always written before the control word, so RD=1 is never visible with a stale pointer.
- WR_CTRL:
  - Write word0.
  - On ack: req_ready pulses 1 cycle, head <= (head==NUM_TX_BD-1) ? 0 : head+1, outstanding+1, -> IDLE.
  - If outstanding was 0, the poll timer loads POLL_INTERVAL.
- RD_STAT:
  - Read word0 of BD[tail].
  - On ack with m_dat_i[15]==0: done_valid=1, done_idx=tail, done_status=m_dat_i[8:0], tail wraps as head does, outstanding-1. If outstanding is still >0, re-enter RD_STAT next cycle (back-to-back retire); else -> IDLE.
  - On ack with m_dat_i[15]==1: reload poll timer = POLL_INTERVAL, -> IDLE.
- Bus timing:
  - cyc and stb rise together and fall the cycle after ack/err.
  - At least one idle cycle between Wishbone cycles.
  - No timeout: the block waits indefinitely for ack/err.
- m_err_i in any state:
  - err_o <= 1 (sticky until reset), cycle ends, -> IDLE.
  - Pending request not consumed; head, tail and outstanding unchanged.
  - An errored WR_CTRL is retried on the next IDLE pass.
- Requirements on the producer:
  - req_valid, req_ptr, req_len and req_irq are held stable from assertion until req_ready.
  - req_len=0 is passed through unchecked.
- outstanding==NUM_TX_BD (full): requests stall, polling continues.
- Simultaneous retire-eligible and request: the poll has priority.

Decomposition:
- Add to the shared MAC info package:
  - Tx BD bit-position constants (RD=15, IRQ=14, WR=13, PAD=12, CRC=11, status 8:0).
  - A packed Tx BD word0 typedef.
  - The FSM state enum.
  - Reuse the existing Tx BD base offset and TX_BD_NUM offset constants.
- Sub-module: wb_single_master.
  - Performs one classic read or write; interface: start, we, adr, wdat -> done, err, rdat.
  - Reused later by an init sequencer.

Test Plan:
- Single frame, ptr=0x1000, len=64, irq=1; slave acks in 2 cycles:
  - Write 0x0000_1000 to 0x404, then 0x0040_D800 to 0x400.
  - req_ready pulses once; outstanding=1.
- Slave clears RD after 3 polls with status 0x010 -> done_valid, done_idx=0, done_status=0x010, outstanding=0.
- Ten queued requests with RD held at 1:
  - 8 BDs written; BD7 word0 has WR=1 (0x0040_F800 for len 64); address 0x438.
  - 9th request stalls with req_ready low.
  - Release BD0 -> 9th request written to BD0 at 0x400.
- Three BDs cleared simultaneously -> three done_valid pulses on consecutive retire cycles, idx 0, 1, 2.
- m_err_i on a WR_CTRL -> err_o=1, outstanding unchanged, same BD rewritten; req_ready only after the acked retry.
- Assert wb_rst_i mid WR_PTR -> m_cyc_o/m_stb_o low in the same cycle, all counters 0; after release, the first write goes to 0x404.

Source files
------------

// File: rtl/mac_tx_bd_sched_pkg.sv
// Shared MAC information: Tx buffer-descriptor layout, ring offsets and the
// scheduler state encoding.
package mac_tx_bd_sched_pkg;

    // Register-map offsets relative to the MAC base address
    localparam logic [31:0] TX_BD_BASE_OFS = 32'h0000_0400;
    localparam logic [31:0] TX_BD_NUM_OFS  = 32'h0000_0020;

    // Tx BD word0 bit positions
    localparam int TXBD_RD_BIT     = 15;
    localparam int TXBD_IRQ_BIT    = 14;
    localparam int TXBD_WR_BIT     = 13;
    localparam int TXBD_PAD_BIT    = 12;
    localparam int TXBD_CRC_BIT    = 11;
    localparam int TXBD_STAT_MSB   = 8;
    localparam int TXBD_STAT_LSB   = 0;

    // Tx BD word0 as the MAC sees it
    typedef struct packed {
        logic [15:0] len;
        logic        rd;
        logic        irq;
        logic        wr;
        logic        pad;
        logic        crc;
        logic [1:0]  rsvd;
        logic [8:0]  status;
    } tx_bd_w0_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_PTR  = 2'd1,
        ST_WR_CTRL = 2'd2,
        ST_RD_STAT = 2'd3
    } tx_sched_state_t;

    // Byte address of word0 of Tx BD number idx
    function automatic logic [31:0] tx_bd_addr(input logic [31:0] base, input logic [6:0] idx);
        return base + TX_BD_BASE_OFS + {22'b0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/mac_tx_bd_sched_wb_single_master.sv
// Single classic Wishbone read or write per start pulse. Bus outputs are
// registered; cyc/stb drop the cycle after ack/err, and done/err pulse then.
module wb_single_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdat,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    // Launch a cycle on start, hold it until ack/err, then report the outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            err     <= 1'b0;
            rdat    <= 32'h0;
            m_adr_o <= 32'h0;
            m_dat_o <= 32'h0;
            m_we_o  <= 1'b0;
            m_sel_o <= 4'h0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (m_cyc_o) begin
                if (m_ack_i || m_err_i) begin
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                    m_sel_o <= 4'h0;
                    done    <= m_ack_i && !m_err_i;
                    err     <= m_err_i;
                    rdat    <= m_dat_i;
                end
            end else if (start) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= we;
                m_sel_o <= 4'hF;
                m_adr_o <= adr;
                m_dat_o <= wdat;
            end
        end
    end

endmodule

// File: rtl/mac_tx_bd_sched.sv
// Tx buffer-descriptor scheduler: writes producer frame requests into the
// MAC's Tx BD ring and retires BDs in order once the MAC clears RD.
module mac_tx_bd_sched
    import mac_tx_bd_sched_pkg::*;
#(
    parameter int          NUM_TX_BD     = 8,
    parameter logic [31:0] MAC_BASE      = 32'h0000_0000,
    parameter int          POLL_INTERVAL = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ptr,
    input  logic [15:0] req_len,
    input  logic        req_irq,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        done_valid,
    output logic [6:0]  done_idx,
    output logic [8:0]  done_status,
    output logic [7:0]  outstanding,
    output logic        err_o
);

    localparam logic [6:0]  LAST_IDX    = 7'(NUM_TX_BD - 1);
    localparam logic [7:0]  RING_SIZE   = 8'(NUM_TX_BD);
    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL);

    tx_sched_state_t state;
    logic [6:0]      head;
    logic [6:0]      tail;
    logic [15:0]     poll_timer;
    logic            bus_start;
    logic            bus_we;
    logic [31:0]     bus_adr;
    logic [31:0]     bus_wdat;
    logic            bus_done;
    logic            bus_err;
    logic [31:0]     bus_rdat;
    tx_bd_w0_t       ctrl_word;
    logic            unused_rdat_bits;

    function automatic logic [6:0] ring_next(input logic [6:0] idx);
        return (idx == LAST_IDX) ? 7'd0 : idx + 7'd1;
    endfunction

    // Control word for the BD at head, built from the held request
    always_comb begin
        ctrl_word        = '0;
        ctrl_word.len    = req_len;
        ctrl_word.rd     = 1'b1;
        ctrl_word.irq    = req_irq;
        ctrl_word.wr     = (head == LAST_IDX);
        ctrl_word.pad    = 1'b1;
        ctrl_word.crc    = 1'b1;
    end

    assign unused_rdat_bits = ^{bus_rdat[31:16], bus_rdat[14:9]};

    // Scheduler FSM: poll-first arbitration, BD writes, in-order retirement
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            head        <= 7'd0;
            tail        <= 7'd0;
            outstanding <= 8'd0;
            poll_timer  <= 16'd0;
            bus_start   <= 1'b0;
            bus_we      <= 1'b0;
            bus_adr     <= 32'h0;
            bus_wdat    <= 32'h0;
            req_ready   <= 1'b0;
            done_valid  <= 1'b0;
            done_idx    <= 7'd0;
            done_status <= 9'd0;
            err_o       <= 1'b0;
        end else begin
            bus_start  <= 1'b0;
            req_ready  <= 1'b0;
            done_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((outstanding != 8'd0) && (poll_timer == 16'd0)) begin
                        state     <= ST_RD_STAT;
                        bus_start <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_adr   <= tx_bd_addr(MAC_BASE, tail);
                        bus_wdat  <= 32'h0;
                    end else if (req_valid && (outstanding < RING_SIZE)) begin
                        state     <= ST_WR_PTR;
                        bus_start <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_adr   <= tx_bd_addr(MAC_BASE, head) + 32'd4;
                        bus_wdat  <= req_ptr;
                    end else if ((poll_timer != 16'd0) && (outstanding != 8'd0)) begin
                        poll_timer <= poll_timer - 16'd1;
                    end
                end
                ST_WR_PTR: begin
                    if (bus_err) begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                    end else if (bus_done) begin
                        state     <= ST_WR_CTRL;
                        bus_start <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_adr   <= tx_bd_addr(MAC_BASE, head);
                        bus_wdat  <= ctrl_word;
                    end
                end
                ST_WR_CTRL: begin
                    if (bus_err) begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                    end else if (bus_done) begin
                        req_ready   <= 1'b1;
                        head        <= ring_next(head);
                        outstanding <= outstanding + 8'd1;
                        if (outstanding == 8'd0) begin
                            poll_timer <= POLL_RELOAD;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_RD_STAT: begin
                    if (bus_err) begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                    end else if (bus_done) begin
                        if (!bus_rdat[TXBD_RD_BIT]) begin
                            done_valid  <= 1'b1;
                            done_idx    <= tail;
                            done_status <= bus_rdat[TXBD_STAT_MSB:TXBD_STAT_LSB];
                            tail        <= ring_next(tail);
                            outstanding <= outstanding - 8'd1;
                            if (outstanding > 8'd1) begin
                                state     <= ST_RD_STAT;
                                bus_start <= 1'b1;
                                bus_we    <= 1'b0;
                                bus_adr   <= tx_bd_addr(MAC_BASE, ring_next(tail));
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            poll_timer <= POLL_RELOAD;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_single_master u_wb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .start   (bus_start),
        .we      (bus_we),
        .adr     (bus_adr),
        .wdat    (bus_wdat),
        .done    (bus_done),
        .err     (bus_err),
        .rdat    (bus_rdat),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i)
    );

endmodule

// File: tb/tb_mac_tx_bd_sched.sv
// Bench for mac_tx_bd_sched: a Wishbone MAC BD-memory model plus scoreboards
// of expected BD writes and expected retirements.
module tb_mac_tx_bd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_ptr = 32'h0;
    logic [15:0] req_len = 16'h0;
    logic        req_irq = 1'b0;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;
    logic [3:0]  m_sel_o;
    logic        done_valid;
    logic [6:0]  done_idx;
    logic [8:0]  done_status;
    logic [7:0]  outstanding;
    logic        err_o;

    mac_tx_bd_sched #(.NUM_TX_BD(8), .MAC_BASE(32'h0), .POLL_INTERVAL(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ptr(req_ptr),
        .req_len(req_len), .req_irq(req_irq),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .done_valid(done_valid), .done_idx(done_idx), .done_status(done_status),
        .outstanding(outstanding), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
    typedef struct { logic [6:0] idx; logic [8:0] st; } done_t;
    wr_t   wq[$];
    done_t dq[$];
    int    done_at[$];

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    int cyc_n = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MAC BD memory model: 2-cycle ack, optional error on a word0 write, RD clearing
    logic [31:0] mem_w0 [0:7];
    logic [31:0] mem_w1 [0:7];
    logic [1:0]  lat;
    logic [2:0]  sidx;
    logic        err_arm = 1'b0;
    logic        clr_go = 1'b0;
    logic [7:0]  clr_mask = 8'h0;
    logic [8:0]  clr_stat = 9'h0;
    assign sidx = m_adr_o[5:3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
            m_dat_i <= 32'h0;
            lat     <= 2'd0;
            for (int i = 0; i < 8; i++) begin
                mem_w0[i] <= 32'h0;
                mem_w1[i] <= 32'h0;
            end
        end else begin
            if (clr_go) begin
                for (int i = 0; i < 8; i++) begin
                    if (clr_mask[i]) mem_w0[i] <= {mem_w0[i][31:16], 1'b0, mem_w0[i][14:9], clr_stat};
                end
            end
            if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
                if (lat == 2'd1) begin
                    lat <= 2'd0;
                    if (m_we_o && !m_adr_o[2] && err_arm) begin
                        m_err_i <= 1'b1;
                    end else begin
                        m_ack_i <= 1'b1;
                        if (m_we_o) begin
                            if (m_adr_o[2]) mem_w1[sidx] <= m_dat_o;
                            else            mem_w0[sidx] <= m_dat_o;
                        end else begin
                            m_dat_i <= mem_w0[sidx];
                        end
                    end
                end else begin
                    lat <= lat + 2'd1;
                end
            end else begin
                m_ack_i <= 1'b0;
                m_err_i <= 1'b0;
                lat     <= 2'd0;
            end
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Output monitor: compares acked writes and retirements against the scoreboards
    wr_t   mon_w;
    done_t mon_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_cyc_o && m_stb_o && m_ack_i && m_we_o) begin
                check_val("wr_sel", {60'h0, m_sel_o}, 64'hF);
                if (wq.size() == 0) begin
                    check_val("wr_unexpected_adr", {32'h0, m_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_w = wq.pop_front();
                    check_val("wr_adr", {32'h0, m_adr_o}, {32'h0, mon_w.adr});
                    check_val("wr_dat", {32'h0, m_dat_o}, {32'h0, mon_w.dat});
                end
            end
            if (m_cyc_o && m_stb_o && m_ack_i && !m_we_o) rd_cnt++;
            if (req_ready) rdy_cnt++;
            if (done_valid) begin
                done_cnt++;
                done_at.push_back(cyc_n);
                if (dq.size() == 0) begin
                    check_val("done_unexpected", {57'h0, done_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_d = dq.pop_front();
                    check_val("done_idx", {57'h0, done_idx}, {57'h0, mon_d.idx});
                    check_val("done_status", {55'h0, done_status}, {55'h0, mon_d.st});
                end
            end
        end
    end

    task automatic push_wr(input int idx, input logic [31:0] ptr, input logic [15:0] len, input logic irq);
        wr_t w;
        logic [31:0] base;
        base  = 32'h400 + 32'(idx) * 32'd8;
        w.adr = base + 32'd4;
        w.dat = ptr;
        wq.push_back(w);
        w.adr = base;
        w.dat = {len, 1'b1, irq, (idx == 7) ? 1'b1 : 1'b0, 1'b1, 1'b1, 11'b0};
        wq.push_back(w);
    endtask

    task automatic drive_req(input logic [31:0] ptr, input logic [15:0] len, input logic irq);
        @(negedge clk);
        req_ptr   = ptr;
        req_len   = len;
        req_irq   = irq;
        req_valid = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            #1;
            if (req_ready) break;
            n++;
        end
        check_val(tag, {63'h0, (n < budget)}, 64'h1);
        req_valid = 1'b0;
    endtask

    task automatic send(input int idx, input logic [31:0] ptr, input logic [15:0] len, input logic irq);
        push_wr(idx, ptr, len, irq);
        drive_req(ptr, len, irq);
        wait_ready("req_ready_timeout", 400);
    endtask

    task automatic clear_bds(input logic [7:0] mask, input logic [8:0] st);
        done_t d;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                d.idx = 7'(i);
                d.st  = st;
                dq.push_back(d);
            end
        end
        @(negedge clk);
        clr_mask = mask;
        clr_stat = st;
        clr_go   = 1'b1;
        @(negedge clk);
        clr_go   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (n < budget && done_cnt < target) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, {63'h0, (done_cnt >= target)}, 64'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, base_rd, base_rdy, base_done, seen;
        do_reset();
        #1;
        check_val("reset_outputs", {56'h0, m_cyc_o, m_stb_o, m_we_o, req_ready, done_valid, err_o, 2'b00, outstanding},
                  64'h0);

        // Single frame, then retire after three polls
        send(0, 32'h0000_1000, 16'd64, 1'b1);
        check_val("t1_outstanding", {56'h0, outstanding}, 64'd1);
        n = 0;
        while (n < 400 && rd_cnt < 3) begin @(posedge clk); #1; n++; end
        check_val("t1_three_polls", {63'h0, (rd_cnt >= 3)}, 64'h1);
        clear_bds(8'h01, 9'h010);
        wait_done("t1_done_timeout", 1, 400);
        check_val("t1_poll_count", 64'(rd_cnt), 64'd4);
        #1;
        check_val("t1_outstanding_0", {56'h0, outstanding}, 64'd0);

        // Ring fill with RD held, stall on full, release oldest BD
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_wr(k % 8, 32'h2000 + 32'(k) * 32'h100, 16'd64, 1'b1);
            drive_req(32'h2000 + 32'(k) * 32'h100, 16'd64, 1'b1);
            if (k >= 8) begin
                seen = 0;
                repeat (80) begin @(negedge clk); #1; if (req_ready) seen = 1; end
                check_val("t2_stall", 64'(seen), 64'd0);
                check_val("t2_full", {56'h0, outstanding}, 64'd8);
                clear_bds(8'(1 << (k - 8)), 9'h000);
            end
            wait_ready("t2_ready_timeout", 400);
        end
        #1;
        check_val("t2_outstanding", {56'h0, outstanding}, 64'd8);

        // Three BDs cleared together retire back to back
        do_reset();
        for (int k = 0; k < 3; k++) send(k, 32'h3000 + 32'(k) * 32'h40, 16'(100 + k), 1'b0);
        base_done = done_at.size();
        clear_bds(8'h07, 9'h1A5);
        wait_done("t3_done_timeout", done_cnt + 3, 400);
        if (done_at.size() >= base_done + 3) begin
            check_val("t3_gap01", {63'h0, (done_at[base_done + 1] - done_at[base_done] < 10)}, 64'h1);
            check_val("t3_gap12", {63'h0, (done_at[base_done + 2] - done_at[base_done + 1] < 10)}, 64'h1);
        end
        #1;
        check_val("t3_outstanding", {56'h0, outstanding}, 64'd0);

        // Error on the control-word write, then retry of the same BD
        do_reset();
        base_rdy = rdy_cnt;
        err_arm  = 1'b1;
        push_wr(0, 32'h0000_5000, 16'd60, 1'b0);
        wq.pop_back();
        push_wr(0, 32'h0000_5000, 16'd60, 1'b0);
        drive_req(32'h0000_5000, 16'd60, 1'b0);
        n = 0;
        while (n < 200) begin @(negedge clk); #1; if (m_err_i) break; n++; end
        check_val("t4_err_seen", {63'h0, (n < 200)}, 64'h1);
        err_arm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("t4_err_o", {63'h0, err_o}, 64'h1);
        check_val("t4_outstanding_kept", {56'h0, outstanding}, 64'd0);
        check_val("t4_no_ready_yet", 64'(rdy_cnt - base_rdy), 64'd0);
        wait_ready("t4_ready_timeout", 400);
        #1;
        check_val("t4_outstanding_1", {56'h0, outstanding}, 64'd1);
        check_val("t4_err_sticky", {63'h0, err_o}, 64'h1);

        // Reset in the middle of the pointer write
        drive_req(32'h0000_6000, 16'd128, 1'b1);
        n = 0;
        while (n < 200) begin @(negedge clk); #1; if (m_cyc_o) break; n++; end
        check_val("t5_ptr_adr", {32'h0, m_adr_o}, 64'h40C);
        rst = 1'b1;
        #1;
        check_val("t5_bus_dropped", {62'h0, m_cyc_o, m_stb_o}, 64'h0);
        check_val("t5_counters", {55'h0, err_o, outstanding}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_wr(0, 32'h0000_6000, 16'd128, 1'b1);
        wait_ready("t5_ready_timeout", 400);
        #1;
        check_val("t5_outstanding", {56'h0, outstanding}, 64'd1);

        repeat (5) @(posedge clk);
        check_val("wr_queue_drained", 64'(wq.size()), 64'd0);
        check_val("done_queue_drained", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
